// File: rtl/avg_pkg.sv
// Shared types and width helpers for the multi-channel block averager.
package avg_pkg;

   typedef enum logic {
      IDLE,
      ACCUM
   } state_t;

   // Wide enough for 2^LOG2_WIN_MAX full-scale samples plus the rounding term.
   function automatic int acc_width(input int in_w, input int log2_win_max);
      return in_w + log2_win_max;
   endfunction

   function automatic int win_width(input int log2_win_max);
      return $clog2(log2_win_max + 1);
   endfunction

endpackage

// File: rtl/avg_ch_acc.sv
// One channel of the block averager: extend, accumulate, round and shift a
// single sample stream under strobes shared by every channel.
module avg_ch_acc
   import avg_pkg::*;
#(
   parameter int IN_W         = 12,
   parameter int LOG2_WIN_MAX = 10,
   parameter int SIGNED       = 0,
   parameter int ROUND        = 0
) (
   input  logic                                iclk,
   input  logic                                irst_n,
   input  logic                                i_clear,
   input  logic                                i_accept,
   input  logic                                i_start,
   input  logic                                i_last,
   input  logic [win_width(LOG2_WIN_MAX)-1:0]  i_k,
   input  logic [IN_W-1:0]                     i_sample,
   output logic [IN_W-1:0]                     o_avg
);

   localparam int AW  = acc_width(IN_W, LOG2_WIN_MAX);
   localparam int AIW = $clog2(AW);

   logic [AW-1:0]   r_acc;
   logic [IN_W-1:0] r_avg;
   logic [AW-1:0]   w_ext;
   logic [AW-1:0]   w_sum;
   logic [AW-1:0]   w_rnd;
   logic [AW-1:0]   w_total;
   logic [IN_W-1:0] w_mean;

   generate
      if (SIGNED != 0) begin : g_sext
         assign w_ext = {{LOG2_WIN_MAX{i_sample[IN_W-1]}}, i_sample};
      end else begin : g_zext
         assign w_ext = {{LOG2_WIN_MAX{1'b0}}, i_sample};
      end

      if (ROUND != 0) begin : g_round
         always_comb begin
            w_rnd = '0;
            if (i_k != '0) begin
               w_rnd[AIW'(i_k) - AIW'(1)] = 1'b1;
            end
         end
      end else begin : g_trunc
         assign w_rnd = '0;
      end
   endgenerate

   assign w_sum   = (i_start ? '0 : r_acc) + w_ext;
   assign w_total = w_sum + w_rnd;

   // The accumulator never overflows, so bit b of the mean is simply bit b+k
   // of the total; this works for both signed and unsigned samples.
   always_comb begin
      w_mean = '0;
      for (int b = 0; b < IN_W; b++) begin
         w_mean[b] = w_total[AIW'(b) + AIW'(i_k)];
      end
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         r_acc <= '0;
         r_avg <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
      end else if (i_accept) begin
         r_acc <= i_last ? '0 : w_sum;
         if (i_last) begin
            r_avg <= w_mean;
         end
      end
   end

   assign o_avg = r_avg;

endmodule

// File: rtl/avg_window_mc.sv
// Multi-channel 2^k block averager: shared window FSM and fill counter,
// one accumulator slice per channel.
module avg_window_mc
   import avg_pkg::*;
#(
   parameter int NUM_CH       = 2,
   parameter int IN_W         = 12,
   parameter int LOG2_WIN_MAX = 10,
   parameter int SIGNED       = 0,
   parameter int ROUND        = 0
) (
   input  logic                                iclk,
   input  logic                                irst_n,
   input  logic                                i_clear,
   input  logic                                i_valid,
   input  logic [NUM_CH*IN_W-1:0]              i_data,
   input  logic [win_width(LOG2_WIN_MAX)-1:0]  i_win_log2,
   output logic                                o_valid,
   output logic [NUM_CH*IN_W-1:0]              o_avg,
   output logic [LOG2_WIN_MAX:0]               o_fill,
   output logic [win_width(LOG2_WIN_MAX)-1:0]  o_win_log2
);

   localparam int KW = win_width(LOG2_WIN_MAX);
   localparam int FW = LOG2_WIN_MAX + 1;

   state_t          r_state;
   logic [FW-1:0]   r_fill;
   logic [KW-1:0]   r_win_log2;
   logic            r_valid;

   logic [KW-1:0]   w_k_req;
   logic [KW-1:0]   w_k_eff;
   logic [FW-1:0]   w_fill_inc;
   logic [FW-1:0]   w_target;
   logic            w_accept;
   logic            w_start;
   logic            w_last;

   // The exponent is only taken from the input at window start; mid-window
   // the latched value governs completion.
   always_comb begin
      w_k_req    = (i_win_log2 > KW'(LOG2_WIN_MAX)) ? KW'(LOG2_WIN_MAX) : i_win_log2;
      w_k_eff    = (r_state == IDLE) ? w_k_req : r_win_log2;
      w_fill_inc = r_fill + FW'(1);
      w_target   = '0;
      w_target[w_k_eff] = 1'b1;
      w_accept   = i_valid & ~i_clear;
      w_start    = w_accept & (r_state == IDLE);
      w_last     = w_accept & (w_fill_inc == w_target);
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         r_state    <= IDLE;
         r_fill     <= '0;
         r_win_log2 <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (i_clear) begin
            r_state <= IDLE;
            r_fill  <= '0;
         end else if (i_valid) begin
            if (r_state == IDLE) begin
               r_win_log2 <= w_k_req;
            end
            if (w_last) begin
               r_valid <= 1'b1;
               r_fill  <= '0;
               r_state <= IDLE;
            end else begin
               r_fill  <= w_fill_inc;
               r_state <= ACCUM;
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         avg_ch_acc #(
            .IN_W         (IN_W),
            .LOG2_WIN_MAX (LOG2_WIN_MAX),
            .SIGNED       (SIGNED),
            .ROUND        (ROUND)
         ) u_acc (
            .iclk     (iclk),
            .irst_n   (irst_n),
            .i_clear  (i_clear),
            .i_accept (w_accept),
            .i_start  (w_start),
            .i_last   (w_last),
            .i_k      (w_k_eff),
            .i_sample (i_data[gi*IN_W +: IN_W]),
            .o_avg    (o_avg[gi*IN_W +: IN_W])
         );
      end
   endgenerate

   assign o_valid    = r_valid;
   assign o_fill     = r_fill;
   assign o_win_log2 = r_win_log2;

endmodule

// File: tb/tb_avg_window_mc.sv
// Bench for avg_window_mc: an unsigned/truncating and a signed/rounding build
// share one stimulus and are checked every cycle against an arithmetic model.
module tb_avg_window_mc;

   localparam int IN_W = 12;
   localparam int NCH  = 2;
   localparam int LMAX = 10;

   logic        iclk       = 1'b0;
   logic        irst_n     = 1'b0;
   logic        i_clear    = 1'b0;
   logic        i_valid    = 1'b0;
   logic [23:0] i_data     = '0;
   logic [3:0]  i_win_log2 = '0;

   logic        ua_valid, sr_valid;
   logic [23:0] ua_avg,   sr_avg;
   logic [10:0] ua_fill,  sr_fill;
   logic [3:0]  ua_win,   sr_win;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 iclk = ~iclk;

   avg_window_mc #(.NUM_CH(NCH), .IN_W(IN_W), .LOG2_WIN_MAX(LMAX), .SIGNED(0), .ROUND(0)) dut_ua (
      .iclk(iclk), .irst_n(irst_n), .i_clear(i_clear), .i_valid(i_valid), .i_data(i_data),
      .i_win_log2(i_win_log2), .o_valid(ua_valid), .o_avg(ua_avg), .o_fill(ua_fill), .o_win_log2(ua_win)
   );

   avg_window_mc #(.NUM_CH(NCH), .IN_W(IN_W), .LOG2_WIN_MAX(LMAX), .SIGNED(1), .ROUND(1)) dut_sr (
      .iclk(iclk), .irst_n(irst_n), .i_clear(i_clear), .i_valid(i_valid), .i_data(i_data),
      .i_win_log2(i_win_log2), .o_valid(sr_valid), .o_avg(sr_avg), .o_fill(sr_fill), .o_win_log2(sr_win)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: running sums and a sample count ----------
   function automatic longint ext(input logic [11:0] v, input bit sgn);
      longint r;
      r = longint'(v);
      if (sgn && v[11]) r = r - 4096;
      return r;
   endfunction

   function automatic logic [11:0] mean(input longint s, input int k, input bit rnd);
      longint t;
      t = s;
      if (rnd && k > 0) t = t + (longint'(1) << (k - 1));
      t = t >>> k;
      return t[11:0];
   endfunction

   int          m_cnt, n_cnt;
   int          m_k,   n_k;
   longint      m_sum_u[NCH], n_sum_u[NCH];
   longint      m_sum_s[NCH], n_sum_s[NCH];
   bit          m_valid, n_valid;
   logic [23:0] m_avg_u, n_avg_u;
   logic [23:0] m_avg_s, n_avg_s;

   always_comb begin
      n_cnt   = m_cnt;
      n_k     = m_k;
      n_sum_u = m_sum_u;
      n_sum_s = m_sum_s;
      n_valid = 1'b0;
      n_avg_u = m_avg_u;
      n_avg_s = m_avg_s;
      if (i_clear) begin
         n_cnt   = 0;
         n_sum_u = '{default: 0};
         n_sum_s = '{default: 0};
      end else if (i_valid) begin
         if (m_cnt == 0) begin
            n_k     = (int'(i_win_log2) > LMAX) ? LMAX : int'(i_win_log2);
            n_sum_u = '{default: 0};
            n_sum_s = '{default: 0};
         end
         n_cnt = m_cnt + 1;
         for (int c = 0; c < NCH; c++) begin
            n_sum_u[c] = n_sum_u[c] + ext(i_data[c*IN_W +: IN_W], 1'b0);
            n_sum_s[c] = n_sum_s[c] + ext(i_data[c*IN_W +: IN_W], 1'b1);
         end
         if (n_cnt == (1 << n_k)) begin
            for (int c = 0; c < NCH; c++) begin
               n_avg_u[c*IN_W +: IN_W] = mean(n_sum_u[c], n_k, 1'b0);
               n_avg_s[c*IN_W +: IN_W] = mean(n_sum_s[c], n_k, 1'b1);
            end
            n_valid = 1'b1;
            n_cnt   = 0;
         end
      end
   end

   always @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         m_cnt   <= 0;
         m_k     <= 0;
         m_sum_u <= '{default: 0};
         m_sum_s <= '{default: 0};
         m_valid <= 1'b0;
         m_avg_u <= '0;
         m_avg_s <= '0;
      end else begin
         m_cnt   <= n_cnt;
         m_k     <= n_k;
         m_sum_u <= n_sum_u;
         m_sum_s <= n_sum_s;
         m_valid <= n_valid;
         m_avg_u <= n_avg_u;
         m_avg_s <= n_avg_s;
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   always @(negedge iclk) begin
      chk("valid_u", longint'(ua_valid), longint'(m_valid));
      chk("avg_u",   longint'(ua_avg),   longint'(m_avg_u));
      chk("fill_u",  longint'(ua_fill),  longint'(m_cnt));
      chk("win_u",   longint'(ua_win),   longint'(m_k));
      chk("valid_s", longint'(sr_valid), longint'(m_valid));
      chk("avg_s",   longint'(sr_avg),   longint'(m_avg_s));
      chk("fill_s",  longint'(sr_fill),  longint'(m_cnt));
      chk("win_s",   longint'(sr_win),   longint'(m_k));
      if (m_valid)
         $display("window k=%0d unsigned ch0=%03h ch1=%03h signed-round ch0=%03h ch1=%03h",
                  m_k, ua_avg[11:0], ua_avg[23:12], sr_avg[11:0], sr_avg[23:12]);
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit v, input logic [11:0] d0, input logic [11:0] d1,
                      input logic [3:0] k, input bit clr);
      i_valid    = v;
      i_data     = {d1, d0};
      i_win_log2 = k;
      i_clear    = clr;
      @(posedge iclk);
      #1;
      i_valid = 1'b0;
      i_clear = 1'b0;
   endtask

   initial begin
      bit pat[7];
      pat = '{1, 0, 0, 1, 1, 0, 1};

      repeat (2) @(posedge iclk);
      #1;
      chk("rst_valid", longint'(ua_valid), 0);
      chk("rst_avg",   longint'(ua_avg),   0);
      chk("rst_fill",  longint'(ua_fill),  0);
      chk("rst_win",   longint'(sr_win),   0);
      irst_n = 1'b1;

      // k=2, ch0 = 4,5,6,7
      cyc(1, 12'd4, 12'd0, 4'd2, 0);
      cyc(1, 12'd5, 12'd0, 4'd2, 0);
      cyc(1, 12'd6, 12'd0, 4'd2, 0);
      chk("t1_fill3", longint'(ua_fill), 3);
      chk("t1_novalid", longint'(ua_valid), 0);
      cyc(1, 12'd7, 12'd0, 4'd2, 0);
      chk("t1_valid",   longint'(ua_valid), 1);
      chk("t1_avg_u",   longint'(ua_avg),   longint'(24'h000005));
      chk("t1_avg_sr",  longint'(sr_avg),   longint'(24'h000006));
      chk("t1_fill0",   longint'(ua_fill),  0);
      chk("t1_win",     longint'(ua_win),   2);
      cyc(0, 12'd0, 12'd0, 4'd2, 0);
      chk("t1_pulse",   longint'(ua_valid), 0);
      chk("t1_hold",    longint'(ua_avg),   longint'(24'h000005));

      // k=10 full scale, no overflow
      for (int i = 0; i < 1024; i++) cyc(1, 12'hFFF, 12'h001, 4'd10, 0);
      chk("t2_valid",  longint'(ua_valid), 1);
      chk("t2_avg_u",  longint'(ua_avg),   longint'(24'h001FFF));
      chk("t2_avg_sr", longint'(sr_avg),   longint'(24'h001FFF));

      // gaps, then back-to-back window starting on the o_valid cycle
      for (int i = 0; i < 7; i++) cyc(pat[i], 12'd8, 12'd0, 4'd2, 0);
      chk("t3_valid", longint'(ua_valid), 1);
      chk("t3_avg",   longint'(ua_avg),   longint'(24'h000008));
      for (int i = 0; i < 4; i++) cyc(1, 12'd16, 12'd3, 4'd2, 0);
      chk("t3_b2b_valid", longint'(ua_valid), 1);
      chk("t3_b2b_avg",   longint'(ua_avg),   longint'(24'h003010));

      // clear with a coincident sample
      cyc(1, 12'd100, 12'd0, 4'd2, 0);
      cyc(1, 12'd100, 12'd0, 4'd2, 0);
      cyc(1, 12'd100, 12'd0, 4'd2, 1);
      chk("t4_novalid", longint'(ua_valid), 0);
      chk("t4_fill",    longint'(ua_fill),  0);
      for (int i = 0; i < 4; i++) cyc(1, 12'd8, 12'd0, 4'd2, 0);
      chk("t4_avg", longint'(ua_avg), longint'(24'h000008));

      // exponent change mid-window
      cyc(1, 12'd20, 12'd0, 4'd2, 0);
      chk("t5_win2", longint'(ua_win), 2);
      for (int i = 0; i < 3; i++) cyc(1, 12'd20, 12'd0, 4'd1, 0);
      chk("t5_valid4", longint'(ua_valid), 1);
      cyc(1, 12'd30, 12'd0, 4'd1, 0);
      chk("t5_win1", longint'(ua_win), 1);
      cyc(1, 12'd30, 12'd0, 4'd1, 0);
      chk("t5_valid2", longint'(ua_valid), 1);
      chk("t5_avg",    longint'(ua_avg),   longint'(24'h00001E));

      // negative samples: -3,-4,-5,-6
      cyc(1, 12'hFFD, 12'd0, 4'd2, 0);
      cyc(1, 12'hFFC, 12'd0, 4'd2, 0);
      cyc(1, 12'hFFB, 12'd0, 4'd2, 0);
      cyc(1, 12'hFFA, 12'd0, 4'd2, 0);
      chk("t6_avg_u",  longint'(ua_avg[11:0]), longint'(12'hFFB));
      chk("t6_avg_sr", longint'(sr_avg[11:0]), longint'(12'hFFC));

      // asynchronous reset mid-window
      for (int i = 0; i < 3; i++) cyc(1, 12'd40, 12'd0, 4'd2, 0);
      #3 irst_n = 1'b0;
      #1;
      chk("t7_valid", longint'(ua_valid), 0);
      chk("t7_avg",   longint'(ua_avg),   0);
      chk("t7_fill",  longint'(ua_fill),  0);
      chk("t7_win",   longint'(sr_win),   0);
      @(posedge iclk);
      #1 irst_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1, 12'd12, 12'd4, 4'd2, 0);
      chk("t7_fresh_valid", longint'(ua_valid), 1);
      chk("t7_fresh_avg",   longint'(ua_avg),   longint'(24'h00400C));

      // randomized traffic, including k above the maximum and sporadic clears
      for (int i = 0; i < 4000; i++) begin
         bit          v, clr;
         logic [3:0]  k;
         v   = ($urandom_range(0, 9) < 7);
         clr = ($urandom_range(0, 49) == 0);
         k   = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 4));
         cyc(v, 12'($urandom), 12'($urandom), k, clr);
      end

      repeat (3) cyc(0, 12'd0, 12'd0, 4'd0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
